awg_loader: RTL and testbench
=============================

# awg_loader

Waveform loader that sits directly upstream of the AWG sample memory. It accepts a 32-bit word stream over a valid/ready handshake and unpacks two 14-bit samples per word. It then drives the memory write port (we/waddr/data) on wclk, starting at a programmed base address for a programmed sample count. It reports busy/done, a sample count and a running checksum so software can confirm the table before enabling playback.

## Interface
- DAC_DATA_WIDTH, 14, sample width; must be ≤ 16.
- ADDR_WIDTH, 16, memory address width; must match the sample memory.
- CSUM_WIDTH, 24, checksum accumulator width.

- wclk  in  1  memory write clock; all logic is on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  single-cycle load request; accepted only in IDLE.
- base_addr  in  ADDR_WIDTH  first write address; sampled on accepted start.
- len  in  ADDR_WIDTH+1  sample count, 0..2^ADDR_WIDTH; sampled on accepted start.
- abort  in  1  returns the block to IDLE at the next edge; no done pulse.
- s_data  in  32  packed word: [DAC_DATA_WIDTH-1:0] is sample n, [16+DAC_DATA_WIDTH-1:16] is sample n+1; other bits are ignored.
- s_valid  in  1  word valid.
- s_ready  out  1  word accepted when s_valid && s_ready.
- we  out  1  memory write enable.
- waddr  out  ADDR_WIDTH  memory write address.
- wdata  out  DAC_DATA_WIDTH  memory write data.
- busy  out  1  high from the accepted start until done or abort.
- done  out  1  single-cycle pulse after the last write.
- count  out  ADDR_WIDTH+1  samples written since the last accepted start.
- csum  out  CSUM_WIDTH  sum of written samples (unsigned) mod 2^CSUM_WIDTH.

## Operation
- States:
  - IDLE: waits for start.
  - RECV: waits for a word.
  - WR_HI: writes the upper sample.
  - DONE: pulses done.
- IDLE:
  - On start, latch base_addr into the address register and len into the remaining register.
  - Clear count and csum.
  - Go to RECV, or to DONE if len == 0.
- RECV:
  - s_ready = 1.
  - On handshake, write the lower sample at the address, increment the address, decrement remaining, and latch the upper sample.
  - Next state is WR_HI if remaining > 1, else DONE. For an odd len, the upper sample of the last word is discarded and not written.
- WR_HI:
  - s_ready = 0.
  - Write the latched upper sample, increment the address, decrement remaining.
  - Next state is RECV if remaining > 1, else DONE.
- DONE:
  - done = 1 for one cycle, then IDLE.
- Address arithmetic is mod 2^ADDR_WIDTH. A load that crosses the top of memory wraps to 0.
- Each write increments count and adds the zero-extended sample to csum (wraps mod 2^CSUM_WIDTH).
- count and csum hold their values in IDLE until the next accepted start.
- start outside IDLE is ignored.
- abort has priority over every transition:
  - Next state is IDLE, we = 0, no done pulse.
  - count and csum keep the values they had up to the abort.
- If start and abort are high in the same IDLE cycle, abort wins and the start is dropped.
- s_data is ignored when s_ready = 0. The word in flight is not consumed.

## Timing
- Reset values: state IDLE; s_ready, we, busy, done = 0; waddr, wdata, count, csum = 0.
- we, waddr and wdata are registered.
- A handshake at edge k produces the lower-sample write visible after edge k (one cycle later).
- The upper-sample write follows after edge k+1.
- s_ready is a decode of the registered state. It is never combinationally dependent on s_valid.
- Maximum throughput is one word per 2 cycles, i.e. one sample per cycle.
- done asserts in the cycle after the final write cycle. busy deasserts together with done.
- For len == 0, done asserts the cycle after start and no write occurs.
- An asynchronous reset mid-load forces all outputs to their reset values immediately. A partial table is left in memory.

## Structure
- Package awg_pkg holds:
  - the state enum (IDLE, RECV, WR_HI, DONE);
  - DAC_DATA_WIDTH and ADDR_WIDTH defaults;
  - the lane offset constant (16) for the upper sample.
- Single module, no sub-module. The unpack, address counter and checksum are each a few registers and stay inline.

## Test plan
- base 0x0000, len 4, words 0x0002_0001, 0x0004_0003 sent back-to-back:
  - writes (0,1), (1,2), (2,3), (3,4) on consecutive cycles;
  - s_ready low every other cycle;
  - done one cycle after the last write; count 4, csum 10.
- Odd length, len 3, same words:
  - three writes; sample 4 is never written;
  - done after the write to address 2; count 3, csum 6.
- Wrap-around, base 0xFFFE, len 4:
  - waddr sequence 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- len 0:
  - done pulse the cycle after start; no we; count 0, csum 0.
- Backpressure and garbage bits:
  - s_valid gaps of 3 cycles between words produce no spurious we;
  - s_data bits [31:30] and [15:14] set high do not appear in wdata (0x3FFF mask).
- abort after the 2nd write of len 8:
  - IDLE next cycle, no done, count 2;
  - a start issued while busy is ignored;
  - a new start after the abort loads normally.

Source files
------------

// File: rtl/awg_pkg.sv
// Shared definitions for the AWG waveform loader: default widths, the
// upper-sample lane offset inside a packed stream word, and the FSM states.
package awg_pkg;

    localparam int DEF_DAC_DATA_WIDTH = 14;
    localparam int DEF_ADDR_WIDTH     = 16;
    localparam int DEF_CSUM_WIDTH     = 24;

    // Sample n+1 sits at this bit offset inside a 32-bit stream word.
    localparam int LANE_OFFSET = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WR_HI = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/awg_loader.sv
// Waveform loader: unpacks two samples per 32-bit stream word and writes them
// to consecutive sample-memory addresses starting at base_addr, for len
// samples. Reports busy/done, a write count and a running checksum.
//
// Stream handshake: a word transfers on a rising wclk edge where
// s_valid && s_ready are both high. s_ready is a pure decode of the
// registered state (high only in RECV) and never looks at s_valid or abort.
module awg_loader
    import awg_pkg::*;
#(
    parameter int DAC_DATA_WIDTH = DEF_DAC_DATA_WIDTH,
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int CSUM_WIDTH     = DEF_CSUM_WIDTH
) (
    input  logic                      wclk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [ADDR_WIDTH-1:0]     base_addr,
    input  logic [ADDR_WIDTH:0]       len,
    input  logic                      abort,
    input  logic [31:0]               s_data,
    input  logic                      s_valid,
    output logic                      s_ready,
    output logic                      we,
    output logic [ADDR_WIDTH-1:0]     waddr,
    output logic [DAC_DATA_WIDTH-1:0] wdata,
    output logic                      busy,
    output logic                      done,
    output logic [ADDR_WIDTH:0]       count,
    output logic [CSUM_WIDTH-1:0]     csum,
    output logic [1:0]                dbg_state
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
    localparam logic [ADDR_WIDTH:0]   REM_ONE  = 1;

    state_t                    state;
    state_t                    state_next;
    logic [ADDR_WIDTH-1:0]     addr;
    logic [ADDR_WIDTH:0]       remaining;
    logic [DAC_DATA_WIDTH-1:0] hi_q;

    logic                      load;
    logic                      hs;
    logic                      wr_en;
    logic                      wr_hi;
    logic [DAC_DATA_WIDTH-1:0] wr_sample;

    // Bits outside both sample lanes are deliberately ignored.
    logic unused_bits;
    assign unused_bits = ^{s_data[31:LANE_OFFSET+DAC_DATA_WIDTH],
                           s_data[LANE_OFFSET-1:DAC_DATA_WIDTH]};

    assign wr_sample = wr_hi ? hi_q : s_data[DAC_DATA_WIDTH-1:0];
    assign busy      = (state != IDLE);
    assign dbg_state = state;

    // Next-state and write-strobe decode; abort overrides every transition.
    always_comb begin
        state_next = state;
        s_ready    = 1'b0;
        load       = 1'b0;
        hs         = 1'b0;
        wr_en      = 1'b0;
        wr_hi      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = (len == '0) ? DONE : RECV;
                end
            end
            RECV: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    hs         = 1'b1;
                    wr_en      = 1'b1;
                    state_next = (remaining > REM_ONE) ? WR_HI : DONE;
                end
            end
            WR_HI: begin
                wr_en      = 1'b1;
                wr_hi      = 1'b1;
                state_next = (remaining > REM_ONE) ? RECV : DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (abort) begin
            state_next = IDLE;
            load       = 1'b0;
            hs         = 1'b0;
            wr_en      = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Datapath: address/remaining counters, upper-sample latch, registered
    // write port, done pulse, count and checksum.
    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            addr      <= '0;
            remaining <= '0;
            hi_q      <= '0;
            we        <= 1'b0;
            waddr     <= '0;
            wdata     <= '0;
            done      <= 1'b0;
            count     <= '0;
            csum      <= '0;
        end else begin
            we   <= wr_en;
            done <= (state == DONE) && !abort;
            if (load) begin
                addr      <= base_addr;
                remaining <= len;
                count     <= '0;
                csum      <= '0;
            end
            if (hs) begin
                hi_q <= s_data[LANE_OFFSET +: DAC_DATA_WIDTH];
            end
            if (wr_en) begin
                waddr     <= addr;
                wdata     <= wr_sample;
                addr      <= addr + ADDR_ONE;
                remaining <= remaining - REM_ONE;
                count     <= count + REM_ONE;
                csum      <= csum + CSUM_WIDTH'(wr_sample);
            end
        end
    end

endmodule

// File: tb/tb_awg_loader.sv
// Testbench for awg_loader: directed and randomized loads checked against a
// sample-list reference model and a write scoreboard.
module tb_awg_loader;

  localparam int DW = 14;
  localparam int AW = 16;
  localparam int CW = 24;

  // ---------------- clock / reset ----------------
  logic          wclk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   len;
  logic          abort;
  logic [31:0]   s_data;
  logic          s_valid;
  logic          s_ready;
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic          busy;
  logic          done;
  logic [AW:0]   count;
  logic [CW-1:0] csum;
  logic [1:0]    dbg_state;

  always #5 wclk = ~wclk;

  awg_loader dut (
    .wclk      (wclk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .abort     (abort),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .count     (count),
    .csum      (csum),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [AW+DW-1:0] exp_q[$];
  logic [31:0]      wq[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int first_we_cyc;
  int last_we_cyc;
  int done_cyc;
  int we_cnt;
  bit done_seen;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample outputs 1ns after the edge; every write
  // strobe is matched against the front of the expected queue.
  task automatic cycle();
    logic [AW+DW-1:0] e;
    @(posedge wclk);
    #1;
    cyc++;
    if (we) begin
      if (exp_q.size() == 0) begin
        check("spurious_we", we, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check("write_addr_data", {waddr, wdata}, e);
      end
      if (first_we_cyc < 0) first_we_cyc = cyc;
      last_we_cyc = cyc;
      we_cnt++;
    end
    if (done) begin
      if (!done_seen) done_cyc = cyc;
      done_seen = 1'b1;
    end
  endtask

  // Reference model: the table is simply sample i at (base + i) mod 2^AW,
  // sample i taken from word i/2, low lane for even i, high lane for odd i.
  task automatic build_expected(input logic [AW-1:0] base, input int n,
                                output logic [CW-1:0] sum);
    logic [31:0]   w;
    logic [DW-1:0] samp;
    logic [AW-1:0] a;
    longint        acc;
    acc = 0;
    for (int i = 0; i < n; i++) begin
      w    = wq[i / 2];
      samp = (i % 2 == 0) ? w[DW-1:0] : w[16+DW-1:16];
      a    = base + i[AW-1:0];
      exp_q.push_back({a, samp});
      acc  = (acc + samp) % (64'd1 << CW);
    end
    sum = acc[CW-1:0];
  endtask

  // Drive one complete load of n samples from wq with `gap` idle cycles of
  // s_valid after each accepted word, then check the end-of-load status.
  task automatic run_load(input logic [AW-1:0] base, input int n, input int gap);
    logic [CW-1:0] sum;
    int wi;
    int gap_left;
    int budget;
    int start_cyc;
    int sready_hi;
    bit hs;
    exp_q.delete();
    build_expected(base, n, sum);
    done_seen    = 1'b0;
    first_we_cyc = -1;
    last_we_cyc  = -1;
    we_cnt       = 0;
    sready_hi    = 0;
    base_addr    = base;
    len          = n[AW:0];
    start        = 1'b1;
    cycle();
    start     = 1'b0;
    start_cyc = cyc;
    check("busy_after_start", busy, 1'b1);
    wi = 0;
    gap_left = 0;
    budget = 0;
    while (!done_seen && budget < 400) begin
      if (gap_left == 0 && wi < wq.size()) begin
        s_valid = 1'b1;
        s_data  = wq[wi];
      end else begin
        s_valid = 1'b0;
        s_data  = $urandom;
      end
      hs = s_valid && s_ready;
      if (s_ready) sready_hi++;
      cycle();
      budget++;
      if (hs) begin
        wi++;
        gap_left = gap;
        check("lo_write_latency", we, 1'b1);
      end else if (gap_left > 0) begin
        gap_left--;
      end
    end
    s_valid = 1'b0;
    check("done_seen", done_seen, 1'b1);
    if (done_seen) begin
      if (n > 0) check("done_after_last_we", done_cyc, last_we_cyc + 1);
      else       check("done_len0_timing", done_cyc, start_cyc + 1);
      check("busy_at_done", busy, 1'b0);
      check("count", count, n);
      check("csum", csum, sum);
      check("write_count", we_cnt, n);
      check("exp_q_drained", exp_q.size(), 0);
      if (gap == 0 && n > 0) begin
        check("b2b_writes", last_we_cyc - first_we_cyc, n - 1);
        check("sready_cycles", sready_hi, (n + 1) / 2);
      end
      cycle();
      check("done_single_pulse", done, 1'b0);
      check("count_hold", count, n);
      check("csum_hold", csum, sum);
    end
    exp_q.delete();
  endtask

  task automatic fill_random_words(input int n);
    wq.delete();
    for (int i = 0; i < (n + 1) / 2; i++) wq.push_back($urandom);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [CW-1:0] asum;
    logic [AW-1:0] rbase;
    int rn;
    rst_n     = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    base_addr = '0;
    len       = '0;
    s_data    = '0;
    s_valid   = 1'b0;
    done_seen = 1'b0;
    first_we_cyc = -1;
    cyc = 0;

    cycle();
    cycle();
    check("rst_s_ready", s_ready, 1'b0);
    check("rst_we", we, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_waddr", waddr, 0);
    check("rst_wdata", wdata, 0);
    check("rst_count", count, 0);
    check("rst_csum", csum, 0);
    rst_n = 1'b1;
    cycle();

    // Basic even load, back-to-back words.
    wq.delete(); wq.push_back(32'h0002_0001); wq.push_back(32'h0004_0003);
    run_load(16'h0000, 4, 0);

    // Odd length: upper sample of the last word is dropped.
    run_load(16'h0000, 3, 0);

    // Wrap across the top of memory.
    run_load(16'hFFFE, 4, 0);

    // Zero-length load.
    wq.delete();
    run_load(16'h0040, 0, 0);

    // Backpressure gaps and garbage bits outside the sample lanes.
    wq.delete(); wq.push_back(32'hC002_C001); wq.push_back(32'hC004_C003);
    run_load(16'h0100, 4, 3);

    // Abort after the second write of an 8-sample load; a start issued while
    // busy must be ignored.
    fill_random_words(8);
    exp_q.delete();
    build_expected(16'h2000, 2, asum);
    done_seen = 1'b0;
    base_addr = 16'h2000;
    len       = 17'd8;
    start     = 1'b1;
    cycle();
    s_valid   = 1'b1;
    s_data    = wq[0];
    base_addr = 16'h1234;
    len       = 17'd2;
    start     = 1'b1;
    cycle();
    s_valid = 1'b0;
    start   = 1'b0;
    check("abort_first_we", we, 1'b1);
    cycle();
    check("abort_second_we", we, 1'b1);
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_we", we, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_count", count, 2);
    check("abort_csum", csum, asum);
    check("abort_exp_drained", exp_q.size(), 0);
    repeat (3) cycle();
    check("abort_no_done", done_seen, 1'b0);
    check("abort_count_hold", count, 2);

    // Start and abort together in IDLE: the start is dropped.
    base_addr = 16'h5555;
    len       = 17'd2;
    start     = 1'b1;
    abort     = 1'b1;
    cycle();
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_busy", busy, 1'b0);
    check("start_abort_count", count, 2);
    cycle();
    check("start_abort_no_done", done, 1'b0);

    // A fresh load after the abort runs normally.
    fill_random_words(6);
    run_load(16'h3000, 6, 1);

    // Randomized loads.
    for (int t = 0; t < 8; t++) begin
      rbase = $urandom;
      rn    = $urandom_range(0, 12);
      fill_random_words(rn);
      run_load(rbase, rn, $urandom_range(0, 3));
    end

    // Asynchronous reset in the middle of a load.
    fill_random_words(6);
    exp_q.delete();
    build_expected(16'h0300, 6, asum);
    base_addr = 16'h0300;
    len       = 17'd6;
    start     = 1'b1;
    cycle();
    start   = 1'b0;
    s_valid = 1'b1;
    s_data  = wq[0];
    cycle();
    s_valid = 1'b0;
    rst_n   = 1'b0;
    #1;
    check("mid_rst_we", we, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_s_ready", s_ready, 1'b0);
    check("mid_rst_count", count, 0);
    check("mid_rst_csum", csum, 0);
    check("mid_rst_waddr", waddr, 0);
    cycle();
    rst_n = 1'b1;
    exp_q.delete();
    cycle();

    // Recovery load after reset.
    fill_random_words(5);
    run_load(16'h7FFD, 5, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
